// File: rtl/vector_scanout_pkg.sv
// Shared pixel layout, palette, and slot phase encoding for the vector scanout path.
// No clocked logic and no backpressure. The rasteriser uses the same pixel layout.
package vector_scanout_pkg;

  localparam int FB_ADDR_WIDTH = 16;
  localparam int COLOUR_MSB    = 7;
  localparam int COLOUR_LSB    = 4;
  localparam int INTENSITY_MSB = 3;
  localparam int INTENSITY_LSB = 0;

  typedef enum logic [1:0] {
    PH_ADDR  = 2'd0,
    PH_LATCH = 2'd1,
    PH_OUT   = 2'd2,
    PH_IDLE  = 2'd3
  } phase_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic logic [3:0] pix_colour(input logic [7:0] pix);
    return pix[COLOUR_MSB:COLOUR_LSB];
  endfunction

  function automatic logic [3:0] pix_intensity(input logic [7:0] pix);
    return pix[INTENSITY_MSB:INTENSITY_LSB];
  endfunction

  // 16-colour CGA-style palette, 24-bit RGB
  function automatic rgb_t palette(input logic [3:0] colour);
    rgb_t c;
    c = 24'h000000;
    case (colour)
      4'h0: c = 24'h000000;
      4'h1: c = 24'h0000AA;
      4'h2: c = 24'h00AA00;
      4'h3: c = 24'h00AAAA;
      4'h4: c = 24'hAA0000;
      4'h5: c = 24'hAA00AA;
      4'h6: c = 24'hAA5500;
      4'h7: c = 24'hAAAAAA;
      4'h8: c = 24'h555555;
      4'h9: c = 24'h5555FF;
      4'hA: c = 24'h55FF55;
      4'hB: c = 24'h55FFFF;
      4'hC: c = 24'hFF5555;
      4'hD: c = 24'hFF55FF;
      4'hE: c = 24'hFFFF55;
      4'hF: c = 24'hFFFFFF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vector_scanout_colour_scale.sv
// Converts a framebuffer byte to RGB through a palette lookup scaled by intensity.
// Purely combinational; there is no backpressure.
module vector_colour_scale
  import vector_scanout_pkg::*;
(
  input  logic [7:0] i_pix,
  output logic [7:0] o_r,
  output logic [7:0] o_g,
  output logic [7:0] o_b,
  output logic       o_a
);

  logic [3:0]  w_int;
  logic [7:0]  w_scale;
  rgb_t        w_pal;
  logic [15:0] w_prod_r;
  logic [15:0] w_prod_g;
  logic [15:0] w_prod_b;
  logic        w_unused;

  assign w_int   = pix_intensity(i_pix);
  assign w_pal   = palette(pix_colour(i_pix));
  // Replicate the nibble so that I=F maps to a full-scale 8-bit factor.
  assign w_scale = {w_int, w_int};

  assign w_prod_r = {8'd0, w_pal.r} * {8'd0, w_scale};
  assign w_prod_g = {8'd0, w_pal.g} * {8'd0, w_scale};
  assign w_prod_b = {8'd0, w_pal.b} * {8'd0, w_scale};

  assign o_r = w_prod_r[15:8];
  assign o_g = w_prod_g[15:8];
  assign o_b = w_prod_b[15:8];
  assign o_a = (w_int != 4'd0);

  assign w_unused = ^{w_prod_r[7:0], w_prod_g[7:0], w_prod_b[7:0]};

endmodule

// File: rtl/vector_scanout.sv
// Raster scanout of the vector framebuffer: palette to RGBA, plus phosphor-fade write-back on port A.
// Colour is registered at the end of slot phase 2. There is no backpressure: a rasteriser write to the same address wins.
module vector_scanout
  import vector_scanout_pkg::*;
#(
  parameter int FB_WIDTH     = 256,
  parameter int FB_HEIGHT    = 256,
  parameter int DECAY_STEP   = 1,
  parameter int DECAY_FRAMES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ce_pix,
  input  logic        i_pause,
  input  logic [8:0]  i_hcnt,
  input  logic [8:0]  i_vcnt,
  input  logic        i_hblank,
  input  logic        i_vblank,
  output logic [15:0] o_fb_addr,
  input  logic [7:0]  i_fb_rd_data,
  output logic        o_fb_wr,
  output logic [7:0]  o_fb_wr_data,
  input  logic [15:0] i_draw_addr,
  input  logic        i_draw_wr,
  output logic [7:0]  o_vector_r,
  output logic [7:0]  o_vector_g,
  output logic [7:0]  o_vector_b,
  output logic        o_vector_a
);

  phase_t     r_phase;
  logic       r_ce_last;
  logic       r_vblank_last;
  logic [7:0] r_pix;
  logic       r_fb_wr;
  logic [7:0] r_fb_wr_data;
  logic [7:0] r_r;
  logic [7:0] r_g;
  logic [7:0] r_b;
  logic       r_a;
  logic [7:0] r_frame_cnt;
  logic       r_decay_en;

  logic       w_ce_rise;
  logic       w_vblank_rise;
  logic       w_in_window;
  logic       w_collide;
  logic       w_wb_en;
  logic [3:0] w_int;
  logic [3:0] w_dec_int;
  logic [7:0] w_decayed;
  logic [7:0] w_scaled_r;
  logic [7:0] w_scaled_g;
  logic [7:0] w_scaled_b;
  logic       w_scaled_a;
  logic       w_last_frame;
  logic       w_unused;

  assign o_fb_addr     = {i_vcnt[7:0], i_hcnt[7:0]};
  assign w_ce_rise     = i_ce_pix & ~r_ce_last;
  assign w_vblank_rise = i_vblank & ~r_vblank_last;
  assign w_in_window   = ({1'b0, i_hcnt} < 10'(FB_WIDTH)) && ({1'b0, i_vcnt} < 10'(FB_HEIGHT));
  assign w_collide     = i_draw_wr && (i_draw_addr == o_fb_addr);

  assign w_int     = pix_intensity(r_pix);
  assign w_dec_int = (w_int > 4'(DECAY_STEP)) ? (w_int - 4'(DECAY_STEP)) : 4'd0;
  // Colour nibble survives a fade to zero so that a redraw at low intensity keeps its hue.
  assign w_decayed = {pix_colour(r_pix), w_dec_int};
  // Dark pixels are never rewritten, which saves port bandwidth.
  assign w_wb_en   = r_decay_en & ~i_pause & ~w_collide & (w_int != 4'd0);

  assign w_last_frame = (r_frame_cnt == 8'(DECAY_FRAMES - 1));
  assign w_unused     = i_hblank;

  vector_colour_scale u_scale (
    .i_pix (r_pix),
    .o_r   (w_scaled_r),
    .o_g   (w_scaled_g),
    .o_b   (w_scaled_b),
    .o_a   (w_scaled_a)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase      <= PH_IDLE;
      r_ce_last    <= 1'b0;
      r_pix        <= 8'd0;
      r_fb_wr      <= 1'b0;
      r_fb_wr_data <= 8'd0;
      r_r          <= 8'd0;
      r_g          <= 8'd0;
      r_b          <= 8'd0;
      r_a          <= 1'b0;
    end else begin
      r_ce_last <= i_ce_pix;
      if (w_ce_rise) begin
        r_phase <= PH_ADDR;
      end else if (r_phase != PH_IDLE) begin
        r_phase <= phase_t'(r_phase + 2'd1);
      end

      case (r_phase)
        PH_ADDR: begin
          r_fb_wr <= 1'b0;
        end
        PH_LATCH: begin
          r_pix <= i_fb_rd_data;
        end
        PH_OUT: begin
          if (w_in_window) begin
            r_r          <= w_scaled_r;
            r_g          <= w_scaled_g;
            r_b          <= w_scaled_b;
            r_a          <= w_scaled_a;
            r_fb_wr      <= w_wb_en;
            r_fb_wr_data <= w_decayed;
          end else begin
            r_r     <= 8'd0;
            r_g     <= 8'd0;
            r_b     <= 8'd0;
            r_a     <= 1'b0;
            r_fb_wr <= 1'b0;
          end
        end
        PH_IDLE: begin
          r_fb_wr <= 1'b0;
        end
        default: begin
          r_fb_wr <= 1'b0;
        end
      endcase
    end
  end

  // decay_en is updated only at vblank, so it holds for the whole following frame
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vblank_last <= 1'b0;
      r_frame_cnt   <= 8'd0;
      r_decay_en    <= 1'b0;
    end else begin
      r_vblank_last <= i_vblank;
      if (w_vblank_rise) begin
        r_frame_cnt <= w_last_frame ? 8'd0 : (r_frame_cnt + 8'd1);
        r_decay_en  <= w_last_frame;
      end
    end
  end

  assign o_fb_wr      = r_fb_wr;
  assign o_fb_wr_data = r_fb_wr_data;
  assign o_vector_r   = r_r;
  assign o_vector_g   = r_g;
  assign o_vector_b   = r_b;
  assign o_vector_a   = r_a;

endmodule

// File: tb/tb_vector_scanout.sv
// Directed bench for vector_scanout: reset, scaling, decay write-back, frame cadence, pause, collision, window.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_vector_scanout;

  logic        clk;
  logic        reset;
  logic        ce_pix;
  logic        pause;
  logic [8:0]  hcnt;
  logic [8:0]  vcnt;
  logic        hblank;
  logic        vblank;
  logic [15:0] fb_addr;
  logic [7:0]  fb_rd_data;
  logic        fb_wr;
  logic [7:0]  fb_wr_data;
  logic [15:0] draw_addr;
  logic        draw_wr;
  logic [7:0]  vr;
  logic [7:0]  vg;
  logic [7:0]  vb;
  logic        va;

  int          checks;
  int          errors;
  int          wr_cnt;
  int          wr_base;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  vector_scanout dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_ce_pix     (ce_pix),
    .i_pause      (pause),
    .i_hcnt       (hcnt),
    .i_vcnt       (vcnt),
    .i_hblank     (hblank),
    .i_vblank     (vblank),
    .o_fb_addr    (fb_addr),
    .i_fb_rd_data (fb_rd_data),
    .o_fb_wr      (fb_wr),
    .o_fb_wr_data (fb_wr_data),
    .i_draw_addr  (draw_addr),
    .i_draw_wr    (draw_wr),
    .o_vector_r   (vr),
    .o_vector_g   (vg),
    .o_vector_b   (vb),
    .o_vector_a   (va)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every clock that the write strobe is high and remembers the last write.
  always @(negedge clk) begin
    if (fb_wr === 1'b1) begin
      wr_cnt  = wr_cnt + 1;
      wr_addr = fb_addr;
      wr_data = fb_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slot(input logic [8:0] h, input logic [8:0] v, input logic [7:0] q);
    @(negedge clk);
    hcnt       = h;
    vcnt       = v;
    fb_rd_data = q;
    ce_pix     = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic vblank_pulse();
    @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_rgba(input string tag, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input logic a);
    chk({tag, "_r"}, 32'(vr), 32'(r));
    chk({tag, "_g"}, 32'(vg), 32'(g));
    chk({tag, "_b"}, 32'(vb), 32'(b));
    chk({tag, "_a"}, 32'(va), 32'(a));
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    wr_cnt     = 0;
    wr_addr    = 16'd0;
    wr_data    = 8'd0;
    reset      = 1'b1;
    ce_pix     = 1'b0;
    pause      = 1'b0;
    hcnt       = 9'd0;
    vcnt       = 9'd0;
    hblank     = 1'b0;
    vblank     = 1'b0;
    fb_rd_data = 8'd0;
    draw_addr  = 16'd0;
    draw_wr    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_rgba("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("reset_wr", 32'(fb_wr), 32'd0);
    chk("reset_wr_data", 32'(fb_wr_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Two vblank edges reach the decay frame; white pixel at (10,20)
    vblank_pulse();
    vblank_pulse();
    hcnt = 9'd10;
    vcnt = 9'd20;
    #1;
    chk("fb_addr_comb", 32'(fb_addr), 32'h140A);
    wr_base = wr_cnt;
    slot(9'd10, 9'd20, 8'hFF);
    chk_rgba("white", 8'hFE, 8'hFE, 8'hFE, 1'b1);
    chk("white_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
    chk("white_wr_addr", 32'(wr_addr), 32'h140A);
    chk("white_wr_data", 32'(wr_data), 32'hFE);

    // Reset held 3 clocks mid-slot drops the pending write and clears outputs
    wr_base = wr_cnt;
    @(negedge clk);
    hcnt       = 9'd11;
    vcnt       = 9'd20;
    fb_rd_data = 8'hFF;
    ce_pix     = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk_rgba("midreset", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("midreset_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);

    // I=1 pixel fades to I=0 with colour preserved
    vblank_pulse();
    vblank_pulse();
    wr_base = wr_cnt;
    slot(9'd5, 9'd5, 8'h31);
    chk_rgba("i1", 8'h00, 8'h0B, 8'h0B, 1'b1);
    chk("i1_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
    chk("i1_wr_data", 32'(wr_data), 32'h30);

    // Next decay frame: I=0 gives no write and a dark pixel
    vblank_pulse();
    vblank_pulse();
    wr_base = wr_cnt;
    slot(9'd5, 9'd5, 8'h30);
    chk_rgba("i0", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("i0_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);

    // Frame cadence: write-back only on every second frame
    for (int k = 1; k <= 4; k++) begin
      vblank_pulse();
      wr_base = wr_cnt;
      slot(9'd7, 9'd9, 8'h15);
      chk($sformatf("frame%0d_wr_cnt", k), 32'(wr_cnt - wr_base), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    chk_rgba("frame_rgb", 8'h00, 8'h00, 8'h38, 1'b1);
    chk("frame_wr_data", 32'(wr_data), 32'h14);

    // Pause suppresses write-back in both frames
    pause   = 1'b1;
    wr_base = wr_cnt;
    vblank_pulse();
    slot(9'd7, 9'd9, 8'h15);
    vblank_pulse();
    slot(9'd7, 9'd9, 8'h15);
    chk("pause_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);
    chk_rgba("pause_rgb", 8'h00, 8'h00, 8'h38, 1'b1);
    pause = 1'b0;

    // Rasteriser collision on the same address wins; a different address does not block
    draw_wr   = 1'b1;
    draw_addr = 16'h0303;
    wr_base   = wr_cnt;
    slot(9'd3, 9'd3, 8'hFF);
    chk("collide_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);
    draw_addr = 16'h0304;
    wr_base   = wr_cnt;
    slot(9'd3, 9'd3, 8'hFF);
    chk("nocollide_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
    chk("nocollide_wr_addr", 32'(wr_addr), 32'h0303);
    draw_wr = 1'b0;

    // Window boundaries
    wr_base = wr_cnt;
    slot(9'd255, 9'd255, 8'hFF);
    chk_rgba("edge_in", 8'hFE, 8'hFE, 8'hFE, 1'b1);
    chk("edge_in_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
    chk("edge_in_wr_addr", 32'(wr_addr), 32'hFFFF);
    wr_base = wr_cnt;
    slot(9'd300, 9'd7, 8'hFF);
    chk_rgba("h300", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("h300_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);
    slot(9'd20, 9'd20, 8'hFF);
    wr_base = wr_cnt;
    slot(9'd10, 9'd256, 8'hFF);
    chk_rgba("v256", 8'h00, 8'h00, 8'h00, 1'b0);
    chk("v256_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);

    // ce_pix edges 2 clocks apart never reach phase 2
    hcnt       = 9'd40;
    vcnt       = 9'd40;
    fb_rd_data = 8'hFF;
    wr_base    = wr_cnt;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      ce_pix = 1'b1;
      @(negedge clk);
      ce_pix = 1'b0;
    end
    chk("fast_ce_wr_cnt", 32'(wr_cnt - wr_base), 32'd0);
    chk("fast_ce_a", 32'(va), 32'd0);
    repeat (6) @(negedge clk);
    chk("fast_ce_tail_wr_cnt", 32'(wr_cnt - wr_base), 32'd1);
    chk("fast_ce_tail_data", 32'(wr_data), 32'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
